// File: rtl/comm_bus_pkg.sv
// Shared definitions for the communication-macro bus bridge.
//  - FSM state encoding for comm_wb_bridge
//  - Default peripheral window (base address and window address width)
//  - Byte offsets of the peripheral sub-windows inside the window
//  - addr_in_window(): window decode helper
package comm_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } bus_state_e;

  localparam logic [31:0] DefBaseAddr = 32'h4000_0000;
  localparam int unsigned DefWinAw    = 10;

  localparam logic [31:0] OffUart  = 32'h0000_0000;
  localparam logic [31:0] OffGpio  = 32'h0000_0100;
  localparam logic [31:0] OffTimer = 32'h0000_0200;
  localparam logic [31:0] OffSpi   = 32'h0000_0300;

  // True when adr lies inside the 2^aw byte window starting at base.
  function automatic logic addr_in_window(input logic [31:0] adr, input logic [31:0] base,
                                          input int unsigned aw);
    return (adr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/comm_wb_watchdog.sv
// Bus watchdog for comm_wb_bridge.
//  clk, rst_n  : clock, asynchronous active-low reset
//  i_clr       : synchronous clear of the cycle counter (has priority over i_en)
//  i_en        : count one cycle
//  o_expired   : high while enabled in the cycle the count reaches TIMEOUT_CYC
module comm_wb_watchdog
  import comm_bus_pkg::*;
#(
  parameter int unsigned TO_W        = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TO_W-1:0] r_cnt;

  // r_cnt holds the number of enabled cycles already completed, so the enabled cycle that
  // observes TIMEOUT_CYC-1 is the one that brings the total to TIMEOUT_CYC.
  assign o_expired = i_en && (r_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/comm_wb_bridge.sv
// Registered Wishbone classic bridge in front of the communication macro.
// Decodes the peripheral window, re-times each request onto the master port, aborts
// accesses the peripheral never answers, and reports errors with sticky status.
//  clk, rst_n        : clock, asynchronous active-low reset
//  s_wb_*            : CPU-side slave port (adr/dat/we/sel/cyc/stb in, dat/ack/err out)
//  m_wb_*            : peripheral-side master port, all outputs registered
//  timeout_flag_o    : sticky, set when the watchdog aborts an access
//  err_count_o       : saturating count of s_wb_err_o pulses
//  clr_status_i      : synchronous clear of timeout_flag_o and err_count_o
module comm_wb_bridge
  import comm_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefBaseAddr,
  parameter int unsigned WIN_AW      = DefWinAw,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  input  logic        s_wb_we_i,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  output logic        s_wb_ack_o,
  output logic        s_wb_err_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic        timeout_flag_o,
  output logic [7:0]  err_count_o,
  input  logic        clr_status_i
);

  localparam logic [31:0] WinMask = (32'h1 << WIN_AW) - 32'h1;

  bus_state_e  r_state;
  logic [31:0] r_s_dat;
  logic        r_s_ack;
  logic        r_s_err;
  logic [31:0] r_m_adr;
  logic [31:0] r_m_dat;
  logic        r_m_we;
  logic [3:0]  r_m_sel;
  logic        r_m_req;
  logic        r_timeout_flag;
  logic [7:0]  r_err_count;

  logic w_req;
  logic w_in_win;
  logic w_wd_expired;
  logic w_err_set;
  logic w_to_set;

  assign w_req    = s_wb_cyc_i && s_wb_stb_i;
  assign w_in_win = addr_in_window(s_wb_adr_i, BASE_ADDR, WIN_AW);

  // Cleared throughout IDLE/RESP, so it always starts from zero on entry to REQ.
  comm_wb_watchdog #(
    .TO_W        (TO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state != StReq),
    .i_en      (r_state == StReq),
    .o_expired (w_wd_expired)
  );

  // Error/timeout events, registered onto s_wb_err_o by the FSM in the same cycle.
  always_comb begin
    w_err_set = 1'b0;
    w_to_set  = 1'b0;
    unique case (r_state)
      StIdle: w_err_set = w_req && !w_in_win;
      StReq: begin
        if (s_wb_cyc_i) begin
          w_err_set = m_wb_err_i || (!m_wb_ack_i && w_wd_expired);
          w_to_set  = !m_wb_err_i && !m_wb_ack_i && w_wd_expired;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_s_dat <= '0;
      r_s_ack <= 1'b0;
      r_s_err <= 1'b0;
      r_m_adr <= '0;
      r_m_dat <= '0;
      r_m_we  <= 1'b0;
      r_m_sel <= '0;
      r_m_req <= 1'b0;
    end else begin
      r_s_ack <= 1'b0;
      r_s_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            if (w_in_win) begin
              r_m_adr <= s_wb_adr_i & WinMask;
              r_m_dat <= s_wb_dat_i;
              r_m_we  <= s_wb_we_i;
              r_m_sel <= s_wb_sel_i;
              r_m_req <= 1'b1;
              r_state <= StReq;
            end else begin
              r_s_err <= 1'b1;
              r_s_dat <= '0;
              r_state <= StResp;
            end
          end
        end
        StReq: begin
          if (!s_wb_cyc_i) begin
            // CPU abandoned the cycle: release the peripheral silently.
            r_m_req <= 1'b0;
            r_state <= StIdle;
          end else if (m_wb_err_i || (!m_wb_ack_i && w_wd_expired)) begin
            r_m_req <= 1'b0;
            r_s_err <= 1'b1;
            r_s_dat <= '0;
            r_state <= StResp;
          end else if (m_wb_ack_i) begin
            r_m_req <= 1'b0;
            r_s_ack <= 1'b1;
            if (!r_m_we) r_s_dat <= m_wb_dat_i;
            r_state <= StResp;
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // A clear in the same cycle as a new error wins; that error is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_flag <= 1'b0;
      r_err_count    <= '0;
    end else if (clr_status_i) begin
      r_timeout_flag <= 1'b0;
      r_err_count    <= '0;
    end else begin
      if (w_to_set) r_timeout_flag <= 1'b1;
      if (w_err_set && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign s_wb_dat_o     = r_s_dat;
  assign s_wb_ack_o     = r_s_ack;
  assign s_wb_err_o     = r_s_err;
  assign m_wb_adr_o     = r_m_adr;
  assign m_wb_dat_o     = r_m_dat;
  assign m_wb_we_o      = r_m_we;
  assign m_wb_sel_o     = r_m_sel;
  assign m_wb_cyc_o     = r_m_req;
  assign m_wb_stb_o     = r_m_req;
  assign timeout_flag_o = r_timeout_flag;
  assign err_count_o    = r_err_count;

endmodule

// File: tb/tb_comm_wb_bridge.sv
// Self-checking bench for comm_wb_bridge: directed vector table, hand-written corner
// sequences, and random transactions checked against a transaction-level model.
module tb_comm_wb_bridge;
  import comm_bus_pkg::*;

  localparam logic [31:0] Base    = 32'h4000_0000;
  localparam int          Timeout = 255;

  // Peripheral behaviour per transaction
  localparam int MNone = 0, MAck = 1, MErr = 2, MBoth = 3;
  // Observed / expected CPU-side response
  localparam int RNone = 0, RAck = 1, RErr = 2, RBoth = 3;

  logic        clk, rst_n;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [3:0]  s_sel;
  logic [31:0] m_adr, m_dat_w, m_dat_r;
  logic        m_we, m_cyc, m_stb, m_ack, m_err;
  logic [3:0]  m_sel;
  logic        to_flag, clr;
  logic [7:0]  err_cnt;

  int          p_mode, p_lat, p_cnt;
  logic [31:0] p_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  logic [31:0] md_sdat;
  logic [7:0]  md_cnt;
  logic        md_flag;

  comm_wb_bridge #(
    .BASE_ADDR   (Base),
    .WIN_AW      (10),
    .TIMEOUT_CYC (Timeout),
    .TO_W        (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_wb_adr_i     (s_adr),
    .s_wb_dat_i     (s_dat_w),
    .s_wb_dat_o     (s_dat_r),
    .s_wb_we_i      (s_we),
    .s_wb_sel_i     (s_sel),
    .s_wb_cyc_i     (s_cyc),
    .s_wb_stb_i     (s_stb),
    .s_wb_ack_o     (s_ack),
    .s_wb_err_o     (s_err),
    .m_wb_adr_o     (m_adr),
    .m_wb_dat_o     (m_dat_w),
    .m_wb_dat_i     (m_dat_r),
    .m_wb_we_o      (m_we),
    .m_wb_sel_o     (m_sel),
    .m_wb_cyc_o     (m_cyc),
    .m_wb_stb_o     (m_stb),
    .m_wb_ack_i     (m_ack),
    .m_wb_err_i     (m_err),
    .timeout_flag_o (to_flag),
    .err_count_o    (err_cnt),
    .clr_status_i   (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_dat_r = p_rdata;

  // Registered peripheral: responds p_lat cycles after it first sees its strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      p_cnt <= 0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (m_cyc && m_stb && !m_ack && !m_err) begin
        if (p_mode != MNone && p_cnt + 1 == p_lat) begin
          m_ack <= (p_mode == MAck) || (p_mode == MBoth);
          m_err <= (p_mode == MErr) || (p_mode == MBoth);
          p_cnt <= 0;
        end else begin
          p_cnt <= p_cnt + 1;
        end
      end else begin
        p_cnt <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of one access, from the bridge's rules rather than its structure.
  task automatic model_txn(input logic [31:0] adr, input logic we, input int mode,
                           input int lat, input logic [31:0] rdata,
                           output int e_resp, output int e_lat, output int e_stb);
    bit to;
    to = 0;
    if ((adr >> 10) != (Base >> 10)) begin
      e_resp = RErr; e_lat = 1; e_stb = 0;
    end else if (mode == MNone || lat >= Timeout) begin
      e_resp = RErr; e_lat = Timeout + 1; e_stb = Timeout; to = 1;
    end else begin
      e_stb  = lat + 1;
      e_lat  = lat + 2;
      e_resp = (mode == MAck) ? RAck : RErr;
    end
    if (e_resp == RErr) begin
      md_sdat = '0;
      if (md_cnt != 8'hFF) md_cnt++;
    end else if (!we) begin
      md_sdat = rdata;
    end
    if (to) md_flag = 1'b1;
  endtask

  task automatic run_txn(input string name, input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, input logic [3:0] sel, input int mode, input int lat,
                         input logic [31:0] rdata, input int e_resp, input int e_lat,
                         input int e_stb, input logic [31:0] e_sdat, input logic [7:0] e_cnt,
                         input logic e_flag);
    int got_lat, got_resp, n_stb, n_cyc;
    logic [31:0] c_adr, c_dat;
    logic c_we;
    logic [3:0] c_sel;
    bit cap;
    p_mode = mode; p_lat = lat; p_rdata = rdata;
    @(negedge clk);
    s_adr = adr; s_dat_w = dat; s_we = we; s_sel = sel; s_cyc = 1'b1; s_stb = 1'b1;
    got_lat = 0; got_resp = RNone; n_stb = 0; n_cyc = 0; cap = 0;
    c_adr = '0; c_dat = '0; c_we = 1'b0; c_sel = '0;
    for (int k = 1; k <= Timeout + 8; k++) begin
      @(negedge clk);
      if (m_stb) n_stb++;
      if (m_cyc) n_cyc++;
      if (m_stb && !cap) begin
        cap = 1; c_adr = m_adr; c_dat = m_dat_w; c_we = m_we; c_sel = m_sel;
      end
      if (s_ack || s_err) begin
        got_lat  = k;
        got_resp = s_err ? (s_ack ? RBoth : RErr) : RAck;
        break;
      end
    end
    s_cyc = 1'b0; s_stb = 1'b0;
    check({name, " resp"}, 32'(got_resp), 32'(e_resp));
    check({name, " latency"}, 32'(got_lat), 32'(e_lat));
    check({name, " m_stb cycles"}, 32'(n_stb), 32'(e_stb));
    check({name, " m_cyc cycles"}, 32'(n_cyc), 32'(e_stb));
    @(negedge clk);
    check({name, " pulse width"}, 32'({s_ack, s_err}), 32'h0);
    check({name, " s_dat_o"}, s_dat_r, e_sdat);
    check({name, " err_count"}, 32'(err_cnt), 32'(e_cnt));
    check({name, " timeout_flag"}, 32'(to_flag), 32'(e_flag));
    if (e_stb > 0) begin
      check({name, " m_adr"}, c_adr, adr & 32'h3FF);
      check({name, " m_dat"}, c_dat, dat);
      check({name, " m_we"}, 32'(c_we), 32'(we));
      check({name, " m_sel"}, 32'(c_sel), 32'(sel));
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          mode;
    int          lat;
    logic [31:0] rdata;
    int          e_resp;
    int          e_lat;
    int          e_stb;
    logic [31:0] e_sdat;
    logic [7:0]  e_cnt;
    logic        e_flag;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int r_resp, r_lat, r_stb, mode, lat, n_evt;
    logic [31:0] adr, dat, rdata;
    logic we;
    logic [3:0] sel;

    vecs[0]  = '{Base + 32'h4, 32'h0000_01B2, 1'b1, 4'hF, MAck, 1, 32'h1111_1111,
                 RAck, 3, 2, 32'h0, 8'd0, 1'b0};
    vecs[1]  = '{Base + OffTimer + 32'h8, 32'h0, 1'b0, 4'hF, MAck, 1, 32'hDEAD_BEEF,
                 RAck, 3, 2, 32'hDEAD_BEEF, 8'd0, 1'b0};
    vecs[2]  = '{Base + OffGpio, 32'h5A5A_0001, 1'b1, 4'h3, MAck, 3, 32'h2222_2222,
                 RAck, 5, 4, 32'hDEAD_BEEF, 8'd0, 1'b0};
    vecs[3]  = '{32'h5000_0000, 32'h0, 1'b0, 4'hF, MAck, 1, 32'h0,
                 RErr, 1, 0, 32'h0, 8'd1, 1'b0};
    vecs[4]  = '{Base + OffSpi, 32'h0, 1'b0, 4'hF, MBoth, 1, 32'h3333_3333,
                 RErr, 3, 2, 32'h0, 8'd2, 1'b0};
    vecs[5]  = '{Base + OffUart, 32'h0, 1'b0, 4'h1, MErr, 2, 32'h0,
                 RErr, 4, 3, 32'h0, 8'd3, 1'b0};
    vecs[6]  = '{Base + 32'h4, 32'h0, 1'b0, 4'hF, MAck, 254, 32'hCAFE_0001,
                 RAck, 256, 255, 32'hCAFE_0001, 8'd3, 1'b0};
    vecs[7]  = '{Base + 32'h3FC, 32'h0, 1'b0, 4'hF, MNone, 1, 32'h0,
                 RErr, 256, 255, 32'h0, 8'd4, 1'b1};
    vecs[8]  = '{Base + 32'h400, 32'h0, 1'b1, 4'hF, MAck, 1, 32'h0,
                 RErr, 1, 0, 32'h0, 8'd5, 1'b1};
    vecs[9]  = '{Base - 32'h4, 32'h0, 1'b0, 4'hF, MAck, 1, 32'h0,
                 RErr, 1, 0, 32'h0, 8'd6, 1'b1};
    vecs[10] = '{Base + OffTimer, 32'h7, 1'b1, 4'hC, MAck, 255, 32'h0,
                 RErr, 256, 255, 32'h0, 8'd7, 1'b1};
    vecs[11] = '{Base + 32'h8, 32'h0, 1'b0, 4'hF, MAck, 1, 32'h1234_5678,
                 RAck, 3, 2, 32'h1234_5678, 8'd7, 1'b1};
    vecs[12] = '{Base + 32'hC, 32'h9, 1'b1, 4'hF, MAck, 2, 32'h8765_4321,
                 RAck, 4, 3, 32'h1234_5678, 8'd7, 1'b1};

    rst_n = 1'b0; clr = 1'b0;
    s_adr = '0; s_dat_w = '0; s_we = 1'b0; s_sel = '0; s_cyc = 1'b0; s_stb = 1'b0;
    p_mode = MNone; p_lat = 1; p_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({s_ack, s_err, m_cyc, m_stb, m_we, to_flag}), 32'h0);
    check("reset s_dat_o", s_dat_r, 32'h0);
    check("reset m_adr|m_dat", m_adr | m_dat_w, 32'h0);
    check("reset err_count|m_sel", 32'({err_cnt, m_sel}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].adr, vecs[i].dat, vecs[i].we, vecs[i].sel,
              vecs[i].mode, vecs[i].lat, vecs[i].rdata, vecs[i].e_resp, vecs[i].e_lat,
              vecs[i].e_stb, vecs[i].e_sdat, vecs[i].e_cnt, vecs[i].e_flag);
    end

    // Status clear
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr timeout_flag", 32'(to_flag), 32'h0);
    check("clr err_count", 32'(err_cnt), 32'h0);
    check("clr keeps s_dat_o", s_dat_r, 32'h1234_5678);

    // Back-to-back out-of-window strobes: each RESP->IDLE re-samples, error every 2 cycles
    @(negedge clk);
    s_adr = 32'h5000_0000; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    n_evt = 0;
    repeat (600) begin
      @(negedge clk);
      if (s_err) n_evt++;
    end
    s_cyc = 1'b0; s_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("held stb error pulses", 32'(n_evt), 32'd300);
    check("err_count saturates", 32'(err_cnt), 32'hFF);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr after saturation", 32'(err_cnt), 32'h0);

    // Clear and new error in the same cycle: clear wins
    clr = 1'b1; s_adr = 32'h5000_0000; s_cyc = 1'b1; s_stb = 1'b1;
    @(negedge clk);
    check("clr+err s_err pulse", 32'(s_err), 32'h1);
    clr = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    check("clr+err count", 32'(err_cnt), 32'h0);
    md_sdat = '0; md_cnt = '0; md_flag = 1'b0;

    // CPU abort in REQ: master released next cycle, no response, no status change
    p_mode = MNone;
    @(negedge clk);
    s_adr = Base + 32'h10; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    repeat (4) @(negedge clk);
    check("abort m_stb before", 32'(m_stb), 32'h1);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    check("abort master dropped", 32'({m_cyc, m_stb}), 32'h0);
    n_evt = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_ack || s_err) n_evt++;
    end
    check("abort no response", 32'(n_evt), 32'h0);
    check("abort err_count", 32'(err_cnt), 32'(md_cnt));

    // Random transactions against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) adr = $urandom;
      else adr = Base | ($urandom & 32'h3FC);
      dat   = $urandom;
      we    = 1'($urandom_range(0, 1));
      sel   = 4'($urandom_range(0, 15));
      rdata = $urandom;
      mode  = ($urandom_range(0, 9) == 0) ? MNone : int'($urandom_range(1, 3));
      lat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(252, 256))
                                          : int'($urandom_range(1, 4));
      model_txn(adr, we, mode, lat, rdata, r_resp, r_lat, r_stb);
      run_txn($sformatf("rnd%0d", t), adr, dat, we, sel, mode, lat, rdata,
              r_resp, r_lat, r_stb, md_sdat, md_cnt, md_flag);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of REQ
    p_mode = MNone;
    @(negedge clk);
    s_adr = Base + 32'h20; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst m_stb before", 32'(m_stb), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst mid-REQ handshake", 32'({m_cyc, m_stb, s_ack, s_err}), 32'h0);
    check("rst mid-REQ status", 32'({to_flag, err_cnt}), 32'h0);
    check("rst mid-REQ s_dat_o", s_dat_r, 32'h0);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_evt = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_ack || s_err || m_stb) n_evt++;
    end
    check("after rst quiet", 32'(n_evt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
